// File: rtl/sd_dma_ctrl_pkg.sv
// Shared types and constants for the sd_dma multi-block sequencer.
package sd_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    GAP,
    FIN
  } state_t;

  localparam int GAP_CYCLES  = 2;
  localparam int ARM_TIMEOUT = 16;
  localparam int WIN_W       = 11;

endpackage

// File: rtl/sd_dma_ctrl_wdog.sv
// Loadable saturating down-counter; expired is high while the count is zero.
module sd_dma_ctrl_wdog #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sd_dma_ctrl.sv
// Multi-block sequencer driving sd_dma one 512-byte block at a time.
// Optional watchdog: define SD_DMA_CTRL_WATCHDOG_EN.
module sd_dma_ctrl
  import sd_dma_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int RUN_TIMEOUT = 8192
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_START,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [7:0]        CMD_BLOCKS,
  input  logic              CMD_PARTIAL,
  input  logic [WIN_W-1:0]  CMD_PART_START,
  input  logic [WIN_W-1:0]  CMD_PART_END,
  input  logic              CMD_ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [7:0]        BLK_REMAIN,
  output logic              DMA_EN,
  input  logic              DMA_STATUS,
  input  logic              DMA_NEXTADDR,
  output logic              DMA_PARTIAL,
  output logic [WIN_W-1:0]  DMA_PART_START,
  output logic [WIN_W-1:0]  DMA_PART_END,
  output logic [ADDR_W-1:0] SRAM_ADDR
);

  state_t     state;
  state_t     next;
  logic [1:0] gap_cnt;
  logic       abort_pend;
  logic       abort_now;
  logic       dec;
  logic       arm_to;
  logic       run_to;
  logic       start_ok;
  logic       tracking;

  assign start_ok = (state == IDLE) && CMD_START;
  assign tracking = (state == ARM) || (state == RUN);
  assign abort_now = abort_pend || CMD_ABORT;

  always_comb begin
    next = state;
    dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (CMD_START)
          next = (CMD_BLOCKS == 8'd0) ? FIN : ARM;
      end
      ARM: begin
        if (DMA_STATUS)  next = RUN;
        else if (arm_to) next = FIN;
      end
      RUN: begin
        if (!DMA_STATUS) begin
          dec  = 1'b1;
          next = (BLK_REMAIN == 8'd1 || abort_now) ? FIN : GAP;
        end else if (run_to) begin
          next = FIN;
        end
      end
      GAP: begin
        if (abort_now)
          next = FIN;
        else if (gap_cnt == 2'(GAP_CYCLES - 1))
          next = ARM;
      end
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      DMA_EN         <= 1'b0;
      gap_cnt        <= '0;
      abort_pend     <= 1'b0;
      BLK_REMAIN     <= '0;
      SRAM_ADDR      <= '0;
      DMA_PARTIAL    <= 1'b0;
      DMA_PART_START <= '0;
      DMA_PART_END   <= '0;
    end else begin
      state   <= next;
      BUSY    <= (next != IDLE);
      DONE    <= (state == FIN);
      DMA_EN  <= (next == ARM);
      gap_cnt <= (state == GAP) ? gap_cnt + 2'd1 : 2'd0;
      if (start_ok) begin
        SRAM_ADDR      <= CMD_ADDR;
        BLK_REMAIN     <= CMD_BLOCKS;
        DMA_PARTIAL    <= CMD_PARTIAL;
        DMA_PART_START <= CMD_PART_START;
        DMA_PART_END   <= CMD_PART_END;
        abort_pend     <= 1'b0;
      end else begin
        if (CMD_ABORT && (tracking || state == GAP))
          abort_pend <= 1'b1;
        if (tracking && DMA_NEXTADDR)
          SRAM_ADDR <= SRAM_ADDR + 1'b1;
        if (dec)
          BLK_REMAIN <= BLK_REMAIN - 8'd1;
      end
    end
  end

`ifdef SD_DMA_CTRL_WATCHDOG_EN
  localparam int WD_MAX = (RUN_TIMEOUT > ARM_TIMEOUT) ? RUN_TIMEOUT
                                                      : ARM_TIMEOUT;
  localparam int WD_W   = $clog2(WD_MAX) + 1;

  logic            wd_load;
  logic            wd_exp;
  logic [WD_W-1:0] wd_val;
  logic            err_q;

  // Reload on every entry into ARM or RUN so each phase gets its own budget.
  assign wd_load = (next != state) && (next == ARM || next == RUN);
  assign wd_val  = (next == ARM) ? WD_W'(ARM_TIMEOUT - 1)
                                 : WD_W'(RUN_TIMEOUT - 1);
  assign arm_to  = (state == ARM) && wd_exp;
  assign run_to  = (state == RUN) && wd_exp;

  sd_dma_ctrl_wdog #(
    .W (WD_W)
  ) u_wdog (
    .clk      (CLK),
    .rst      (RST),
    .load     (wd_load),
    .en       (tracking),
    .load_val (wd_val),
    .expired  (wd_exp)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      err_q <= 1'b0;
    else if (start_ok)
      err_q <= 1'b0;
    else if ((arm_to && !DMA_STATUS) || (run_to && DMA_STATUS))
      err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  logic unused_cfg;

  assign arm_to     = 1'b0;
  assign run_to     = 1'b0;
  assign ERR        = 1'b0;
  assign unused_cfg = (RUN_TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_sd_dma_ctrl.sv
// Directed bench for sd_dma_ctrl with a behavioural sd_dma block model.
module tb_sd_dma_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_START = 1'b0;
  logic [23:0] CMD_ADDR = '0;
  logic [7:0]  CMD_BLOCKS = '0;
  logic        CMD_PARTIAL = 1'b0;
  logic [10:0] CMD_PART_START = '0;
  logic [10:0] CMD_PART_END = '0;
  logic        CMD_ABORT = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [7:0]  BLK_REMAIN;
  logic        DMA_EN;
  logic        DMA_STATUS;
  logic        DMA_NEXTADDR;
  logic        DMA_PARTIAL;
  logic [10:0] DMA_PART_START;
  logic [10:0] DMA_PART_END;
  logic [23:0] SRAM_ADDR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sd_dma_ctrl #(
    .ADDR_W      (24),
    .RUN_TIMEOUT (8192)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .CMD_START      (CMD_START),
    .CMD_ADDR       (CMD_ADDR),
    .CMD_BLOCKS     (CMD_BLOCKS),
    .CMD_PARTIAL    (CMD_PARTIAL),
    .CMD_PART_START (CMD_PART_START),
    .CMD_PART_END   (CMD_PART_END),
    .CMD_ABORT      (CMD_ABORT),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .ERR            (ERR),
    .BLK_REMAIN     (BLK_REMAIN),
    .DMA_EN         (DMA_EN),
    .DMA_STATUS     (DMA_STATUS),
    .DMA_NEXTADDR   (DMA_NEXTADDR),
    .DMA_PARTIAL    (DMA_PARTIAL),
    .DMA_PART_START (DMA_PART_START),
    .DMA_PART_END   (DMA_PART_END),
    .SRAM_ADDR      (SRAM_ADDR)
  );

  // sd_dma model: 2-flop enable sync, rising-edge start, one strobe per byte
  logic en_s1 = 1'b0;
  logic en_s2 = 1'b0;
  logic en_s3 = 1'b0;
  logic m_busy = 1'b0;
  logic m_status = 1'b0;
  logic m_next = 1'b0;
  int   m_cnt = 0;
  bit   model_dead = 1'b0;
  logic en_prev = 1'b0;
  int   en_edges = 0;
  int   done_cnt = 0;

  assign DMA_STATUS   = m_status;
  assign DMA_NEXTADDR = m_next;

  always @(posedge CLK) begin
    en_s1 <= DMA_EN;
    en_s2 <= en_s1;
    en_s3 <= en_s2;
    en_prev <= DMA_EN;
    if (DMA_EN && !en_prev) en_edges <= en_edges + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (!m_busy) begin
      m_next <= 1'b0;
      if (en_s2 && !en_s3 && !model_dead) begin
        m_busy   <= 1'b1;
        m_status <= 1'b1;
        m_cnt    <= DMA_PARTIAL ?
                    int'(DMA_PART_END) - int'(DMA_PART_START) : 512;
      end
    end else if (m_cnt != 0) begin
      m_next <= 1'b1;
      m_cnt  <= m_cnt - 1;
    end else begin
      m_next   <= 1'b0;
      m_status <= 1'b0;
      m_busy   <= 1'b0;
    end
  end

  task automatic start_cmd(input logic [23:0] a, input logic [7:0] b,
                           input logic p, input logic [10:0] ps,
                           input logic [10:0] pe);
    @(negedge CLK);
    CMD_ADDR       = a;
    CMD_BLOCKS     = b;
    CMD_PARTIAL    = p;
    CMD_PART_START = ps;
    CMD_PART_END   = pe;
    CMD_START      = 1'b1;
    @(negedge CLK);
    CMD_START      = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < limit; i++) begin
      if (DONE === 1'b1) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_model_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!m_busy && !m_status && !en_s1 && !en_s2 && !en_s3) break;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({BUSY, DONE, ERR, DMA_EN, DMA_PARTIAL} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {BUSY, DONE, ERR, DMA_EN, DMA_PARTIAL});
    end
    n_cmp++;
    if (SRAM_ADDR !== 24'h0 || BLK_REMAIN !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_regs addr=%h blk=%0d want 0/0",
               SRAM_ADDR, BLK_REMAIN);
    end
    n_cmp++;
    if (DMA_PART_START !== 11'h0 || DMA_PART_END !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_window got=%0d/%0d want=0/0",
               DMA_PART_START, DMA_PART_END);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_multi_block();
    int  cyc;
    bit  ok;
    int  e0;
    int  d0;
    e0 = en_edges;
    d0 = done_cnt;
    start_cmd(24'h001000, 8'd3, 1'b0, 11'd0, 11'd0);
    n_cmp++;
    if (DMA_EN !== 1'b1 || BUSY !== 1'b1 || BLK_REMAIN !== 8'd3) begin
      n_bad++;
      $display("FAIL multi_start en=%b busy=%b blk=%0d want 1/1/3",
               DMA_EN, BUSY, BLK_REMAIN);
    end
    wait_done(5000, cyc, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL multi_timeout done=%b want 1", DONE);
    end
    n_cmp++;
    if (SRAM_ADDR !== 24'h001600 || BLK_REMAIN !== 8'd0) begin
      n_bad++;
      $display("FAIL multi_end addr=%h blk=%0d want 001600/0",
               SRAM_ADDR, BLK_REMAIN);
    end
    n_cmp++;
    if (BUSY !== 1'b0 || ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL multi_busy busy=%b err=%b want 0/0", BUSY, ERR);
    end
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (en_edges - e0 != 3 || done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL multi_counts edges=%0d dones=%0d want 3/1",
               en_edges - e0, done_cnt - d0);
    end
  endtask

  task automatic test_partial();
    int cyc;
    bit ok;
    start_cmd(24'h000200, 8'd1, 1'b1, 11'd16, 11'd48);
    n_cmp++;
    if (DMA_PARTIAL !== 1'b1 || DMA_PART_START !== 11'd16 ||
        DMA_PART_END !== 11'd48) begin
      n_bad++;
      $display("FAIL partial_ports got=%b %0d/%0d want 1 16/48",
               DMA_PARTIAL, DMA_PART_START, DMA_PART_END);
    end
    wait_done(2000, cyc, ok);
    n_cmp++;
    if (!ok || SRAM_ADDR !== 24'h000220) begin
      n_bad++;
      $display("FAIL partial_addr ok=%b addr=%h want 1/000220",
               ok, SRAM_ADDR);
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit ok;
    int e0;
    e0 = en_edges;
    start_cmd(24'h004000, 8'd4, 1'b0, 11'd0, 11'd0);
    for (int i = 0; i < 50 && DMA_STATUS !== 1'b1; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    CMD_ABORT      = 1'b1;
    CMD_START      = 1'b1;
    CMD_ADDR       = 24'hABCDEF;
    CMD_BLOCKS     = 8'd9;
    CMD_PARTIAL    = 1'b1;
    CMD_PART_START = 11'd5;
    CMD_PART_END   = 11'd9;
    @(negedge CLK);
    CMD_ABORT = 1'b0;
    CMD_START = 1'b0;
    n_cmp++;
    if (DMA_PARTIAL !== 1'b0 || DMA_PART_START !== 11'd0 ||
        DMA_PART_END !== 11'd0 || BLK_REMAIN !== 8'd4) begin
      n_bad++;
      $display("FAIL abort_latched p=%b %0d/%0d blk=%0d want 0 0/0 4",
               DMA_PARTIAL, DMA_PART_START, DMA_PART_END, BLK_REMAIN);
    end
    wait_done(2000, cyc, ok);
    n_cmp++;
    if (!ok || BLK_REMAIN !== 8'd3 || SRAM_ADDR !== 24'h004200) begin
      n_bad++;
      $display("FAIL abort_end ok=%b blk=%0d addr=%h want 1/3/004200",
               ok, BLK_REMAIN, SRAM_ADDR);
    end
    repeat (6) @(negedge CLK);
    n_cmp++;
    if (en_edges - e0 != 1 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_edges edges=%0d busy=%b want 1/0",
               en_edges - e0, BUSY);
    end
  endtask

  task automatic test_zero_wrap();
    int cyc;
    bit ok;
    int e0;
    e0 = en_edges;
    start_cmd(24'h000040, 8'd0, 1'b0, 11'd0, 11'd0);
    wait_done(20, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 1) begin
      n_bad++;
      $display("FAIL zero_latency ok=%b cyc=%0d want 1/1", ok, cyc);
    end
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (en_edges != e0 || SRAM_ADDR !== 24'h000040) begin
      n_bad++;
      $display("FAIL zero_noen edges=%0d addr=%h want 0/000040",
               en_edges - e0, SRAM_ADDR);
    end
    start_cmd(24'hFFFF00, 8'd1, 1'b0, 11'd0, 11'd0);
    wait_done(2000, cyc, ok);
    n_cmp++;
    if (!ok || SRAM_ADDR !== 24'h000100) begin
      n_bad++;
      $display("FAIL wrap_addr ok=%b addr=%h want 1/000100",
               ok, SRAM_ADDR);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    start_cmd(24'h008000, 8'd2, 1'b0, 11'd0, 11'd0);
    for (int i = 0; i < 50 && DMA_STATUS !== 1'b1; i++) @(negedge CLK);
    repeat (40) @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({BUSY, DONE, DMA_EN} !== 3'b0 || SRAM_ADDR !== 24'h0 ||
        BLK_REMAIN !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_async busy/done/en=%b addr=%h blk=%0d want 0",
               {BUSY, DONE, DMA_EN}, SRAM_ADDR, BLK_REMAIN);
    end
    @(negedge CLK);
    RST = 1'b0;
    wait_model_idle();
    start_cmd(24'h000100, 8'd1, 1'b0, 11'd0, 11'd0);
    wait_done(2000, cyc, ok);
    n_cmp++;
    if (!ok || SRAM_ADDR !== 24'h000300 || BLK_REMAIN !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_after ok=%b addr=%h blk=%0d want 1/000300/0",
               ok, SRAM_ADDR, BLK_REMAIN);
    end
  endtask

`ifdef SD_DMA_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    int cyc;
    bit ok;
    model_dead = 1'b1;
    start_cmd(24'h000000, 8'd2, 1'b0, 11'd0, 11'd0);
    wait_done(100, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 17 || ERR !== 1'b1) begin
      n_bad++;
      $display("FAIL wdog_trip ok=%b cyc=%0d err=%b want 1/17/1",
               ok, cyc, ERR);
    end
    n_cmp++;
    if (DMA_EN !== 1'b0 || BLK_REMAIN !== 8'd2) begin
      n_bad++;
      $display("FAIL wdog_state en=%b blk=%0d want 0/2", DMA_EN, BLK_REMAIN);
    end
    model_dead = 1'b0;
    repeat (5) @(negedge CLK);
    start_cmd(24'h000000, 8'd1, 1'b0, 11'd0, 11'd0);
    n_cmp++;
    if (ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL wdog_clear err=%b want 0", ERR);
    end
    wait_done(2000, cyc, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_multi_block();
    test_partial();
    test_abort();
    test_zero_wrap();
    test_reset_mid();
`ifdef SD_DMA_CTRL_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
